// File: rtl/instr_pkg.sv
// Shared types, constants and the move-encoding table for the 9-bit ISA emitter.
package instr_pkg;

    typedef enum logic [1:0] {
        KIND_REG  = 2'd0,
        KIND_IMM  = 2'd1,
        KIND_MOVE = 2'd2,
        KIND_END  = 2'd3
    } kind_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_IMM_RANGE = 2'd1;
    localparam logic [1:0] ERR_BAD_MOVE  = 2'd2;
    localparam logic [1:0] ERR_REG_ALIAS = 2'd3;

    localparam logic [1:0] IMM_PREFIX = 2'b10;
    localparam logic [1:0] REG_PREFIX = 2'b00;

    localparam logic [8:0] MOVE_INVALID = 9'h1FF;

    // Indexed by {dst, src}; the diagonal (dst == src) has no encoding.
    localparam logic [8:0] MOVE_LUT [16] = '{
        9'h1FF, 9'h004, 9'h008, 9'h00C,
        9'h009, 9'h1FF, 9'h00D, 9'h00E,
        9'h014, 9'h018, 9'h1FF, 9'h01C,
        9'h019, 9'h01D, 9'h01E, 9'h1FF
    };

    function automatic logic [8:0] encode_move(input logic [1:0] dst, input logic [1:0] src);
        return MOVE_LUT[{dst, src}];
    endfunction

    function automatic logic is_move_word(input logic [8:0] word);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (MOVE_LUT[i] != MOVE_INVALID && MOVE_LUT[i] == word) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: one decoded record in, one encoded word plus write enable
// and rejection code out. END records yield neither a write nor an error.
module instr_pack
    import instr_pkg::*;
(
    input  kind_t      kind_i,
    input  logic [2:0] opcode_i,
    input  logic [1:0] ra_i,
    input  logic [1:0] rb_i,
    input  logic [7:0] imm_i,
    output logic [8:0] word_o,
    output logic       write_en_o,
    output logic [1:0] err_code_o
);

    logic [8:0] reg_word;
    logic [8:0] move_word;

    assign reg_word  = {REG_PREFIX, opcode_i, ra_i, rb_i};
    assign move_word = encode_move(ra_i, rb_i);

    always_comb begin
        word_o     = 9'h000;
        write_en_o = 1'b0;
        err_code_o = ERR_NONE;
        case (kind_i)
            KIND_REG: begin
                // A register op that collides with a move encoding would decode as a move.
                if (is_move_word(reg_word)) begin
                    err_code_o = ERR_REG_ALIAS;
                end else begin
                    word_o     = reg_word;
                    write_en_o = 1'b1;
                end
            end
            KIND_IMM: begin
                if (imm_i[7] != imm_i[6]) begin
                    err_code_o = ERR_IMM_RANGE;
                end else begin
                    word_o     = {IMM_PREFIX, imm_i[6:0]};
                    write_en_o = 1'b1;
                end
            end
            KIND_MOVE: begin
                if (move_word == MOVE_INVALID) begin
                    err_code_o = ERR_BAD_MOVE;
                end else begin
                    word_o     = move_word;
                    write_en_o = 1'b1;
                end
            end
            default: begin
                word_o     = 9'h000;
                write_en_o = 1'b0;
                err_code_o = ERR_NONE;
            end
        endcase
    end

endmodule

// File: rtl/instr_emitter.sv
// Instruction loader: accepts decoded records, packs them and writes the words
// sequentially into instruction memory, with a sticky first-error report.
module instr_emitter
    import instr_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [2:0]        in_opcode,
    input  logic [1:0]        in_ra,
    input  logic [1:0]        in_rb,
    input  logic [7:0]        in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [8:0]        imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output state_t            dbg_state
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    state_t            state_q;
    logic [ADDR_W:0]   ptr_q;
    logic [ADDR_W:0]   ptr_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [8:0]        wdata_q;
    logic              done_q;
    logic              err_q;
    logic [1:0]        code_q;

    logic              accept;
    logic [8:0]        pk_word;
    logic              pk_we;
    logic [1:0]        pk_err;
    kind_t             kind;

    assign kind = kind_t'(in_kind);

    instr_pack u_pack (
        .kind_i     (kind),
        .opcode_i   (in_opcode),
        .ra_i       (in_ra),
        .rb_i       (in_rb),
        .imm_i      (in_imm),
        .word_o     (pk_word),
        .write_en_o (pk_we),
        .err_code_o (pk_err)
    );

    // Handshake: a record transfers on a rising edge where in_valid && in_ready; the
    // producer holds the record stable until then. in_ready depends only on registers.
    assign in_ready = (state_q == ST_LOAD) && (ptr_q < DEPTH_W);
    assign accept   = in_valid && in_ready;
    assign ptr_d    = ptr_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 9'h000;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q <= ST_LOAD;
                        ptr_q   <= '0;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        code_q  <= ERR_NONE;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (pk_we) begin
                            we_q    <= 1'b1;
                            addr_q  <= ptr_q[ADDR_W-1:0];
                            wdata_q <= pk_word;
                            ptr_q   <= ptr_d;
                            // Filling the last slot ends the load; the write itself still issues.
                            if (ptr_d == DEPTH_W) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end
                        end
                        if (pk_err != ERR_NONE && !err_q) begin
                            err_q  <= 1'b1;
                            code_q <= pk_err;
                        end
                        if (kind == KIND_END) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign word_count = ptr_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = code_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_instr_emitter.sv
// Directed and randomized checks of the instruction emitter against a record-level model.
module tb_instr_emitter;
    import instr_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int W      = ADDR_W + 9;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        in_kind = 2'd0;
    logic [2:0]        in_opcode = 3'd0;
    logic [1:0]        in_ra = 2'd0;
    logic [1:0]        in_rb = 2'd0;
    logic [7:0]        in_imm = 8'd0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [8:0]        imem_wdata;
    logic [ADDR_W:0]   word_count;
    logic              done;
    logic              err;
    logic [1:0]        err_code;
    state_t            dbg_state;

    instr_emitter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_opcode  (in_opcode),
        .in_ra      (in_ra),
        .in_rb      (in_rb),
        .in_imm     (in_imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .word_count (word_count),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // Model: 0 = idle, 1 = loading, 2 = finished.
    int m_mode = 0;
    int m_ptr  = 0;
    bit m_err  = 0;
    int m_code = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_move_pattern(input int w);
        case (w)
            'h004, 'h008, 'h00C, 'h009, 'h00D, 'h00E,
            'h014, 'h018, 'h01C, 'h019, 'h01D, 'h01E: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int move_word(input int d, input int s);
        case (d * 10 + s)
            1:  return 'h004;
            2:  return 'h008;
            3:  return 'h00C;
            10: return 'h009;
            12: return 'h00D;
            13: return 'h00E;
            20: return 'h014;
            21: return 'h018;
            23: return 'h01C;
            30: return 'h019;
            31: return 'h01D;
            32: return 'h01E;
            default: return -1;
        endcase
    endfunction

    task automatic model_pack(input int k, input int op, input int ra, input int rb, input int imm,
                              output bit wr, output int word, output int code);
        int s;
        wr = 0;
        word = 0;
        code = 0;
        if (k == 0) begin
            word = op * 16 + ra * 4 + rb;
            if (is_move_pattern(word)) code = 3;
            else wr = 1;
        end else if (k == 1) begin
            s = (imm >= 128) ? imm - 256 : imm;
            if (s < -64 || s > 63) code = 1;
            else begin
                wr = 1;
                word = 256 + (imm % 128);
            end
        end else if (k == 2) begin
            if (ra == rb) code = 2;
            else begin
                wr = 1;
                word = move_word(ra, rb);
            end
        end
    endtask

    task automatic check_status(input string tag);
        chk({tag, ".word_count"}, word_count, m_ptr);
        chk({tag, ".done"}, done, (m_mode == 2));
        chk({tag, ".err"}, err, m_err);
        chk({tag, ".err_code"}, err_code, m_code);
    endtask

    task automatic step(input string tag, input bit st, input bit v, input int k,
                        input int op, input int ra, input int rb, input int imm);
        bit exp_ready;
        bit wr;
        int word;
        int code;
        int mode_before;
        logic [W-1:0] e;
        @(negedge clk);
        start = st;
        in_valid = v;
        in_kind = k[1:0];
        in_opcode = op[2:0];
        in_ra = ra[1:0];
        in_rb = rb[1:0];
        in_imm = imm[7:0];
        exp_ready = (m_mode == 1) && (m_ptr < DEPTH);
        #1;
        chk({tag, ".in_ready"}, in_ready, exp_ready);
        @(posedge clk);
        mode_before = m_mode;
        wr = 0;
        if (v && exp_ready) begin
            model_pack(k, op, ra, rb, imm, wr, word, code);
            if (wr) begin
                e = {m_ptr[ADDR_W-1:0], word[8:0]};
                exp_q.push_back(e);
                m_ptr++;
                if (m_ptr == DEPTH) m_mode = 2;
            end
            if (code != 0 && !m_err) begin
                m_err = 1;
                m_code = code;
            end
            if (k == 3) m_mode = 2;
        end
        if (st && mode_before != 1) begin
            m_mode = 1;
            m_ptr = 0;
            m_err = 0;
            m_code = 0;
        end
        #1;
        chk({tag, ".imem_we"}, imem_we, wr);
        if (wr && exp_q.size() > 0) chk({tag, ".write"}, {imem_addr, imem_wdata}, exp_q.pop_front());
        check_status(tag);
        start = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".in_ready"}, in_ready, 0);
        chk({tag, ".imem_we"}, imem_we, 0);
        chk({tag, ".imem_addr"}, imem_addr, 0);
        chk({tag, ".imem_wdata"}, imem_wdata, 0);
        chk({tag, ".word_count"}, word_count, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".err"}, err, 0);
        chk({tag, ".err_code"}, err_code, 0);
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_ptr = 0;
        m_err = 0;
        m_code = 0;
        exp_q.delete();
    endtask

    task automatic restart(input string tag);
        if (m_mode == 1) step({tag, ".end"}, 0, 1, 3, 0, 0, 0, 0);
        step({tag, ".start"}, 1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // start together with a valid record in IDLE: start wins, nothing accepted.
        step("start_wins", 1, 1, 0, 3, 2, 1, 0);
        step("reg_039", 0, 1, 0, 3, 2, 1, 0);
        step("imm_17d", 0, 1, 1, 0, 0, 0, 'hFD);

        restart("r1");
        step("imm_range", 0, 1, 1, 0, 0, 0, 'h40);
        step("imm_13f", 0, 1, 1, 0, 0, 0, 'h3F);
        step("move_01d", 0, 1, 2, 0, 3, 1, 0);
        step("start_in_load", 1, 0, 0, 0, 0, 0, 0);

        restart("r2");
        step("move_same", 0, 1, 2, 0, 2, 2, 0);
        step("alias_after_err", 0, 1, 0, 1, 1, 0, 0);

        restart("r3");
        step("reg_alias", 0, 1, 0, 1, 1, 0, 0);
        step("reg_ok", 0, 1, 0, 7, 3, 3, 0);

        restart("r4");
        for (int i = 0; i < 6; i++) step("full_stream", 0, 1, 0, 4 + (i % 4), i % 4, 3 - (i % 4), 0);

        restart("r5");
        step("mid_bad_imm", 0, 1, 1, 0, 0, 0, 'h80);
        step("mid_reg", 0, 1, 0, 2, 1, 1, 0);
        step("mid_end", 0, 1, 3, 0, 0, 0, 0);
        step("restart_clear", 1, 0, 0, 0, 0, 0, 0);
        step("restart_addr0", 0, 1, 0, 5, 0, 1, 0);

        step("pre_reset_write", 0, 1, 2, 0, 1, 2, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 400; n++) begin
            int r;
            int k;
            r = $urandom_range(0, 19);
            k = (r == 0) ? 3 : (r < 8) ? 0 : (r < 14) ? 1 : 2;
            step("random", ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0), k,
                 $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 255));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
